// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared constants, cycle conversion and FSM states for input_conditioner.
package input_cond_pkg;
  localparam int DB_MIN = 2;
  typedef enum logic {INIT, RUN} state_t;
  function automatic int ms_to_cyc(input int hz, input int ms);
    return hz / 1000 * ms;
  endfunction
  function automatic int db_cycles(input int hz, input int ms);
    return (ms_to_cyc(hz, ms) < DB_MIN) ? DB_MIN : ms_to_cyc(hz, ms);
  endfunction
endpackage

// File: rtl/input_conditioner_debounce_cell.sv
// debounce_cell: 2-FF synchroniser plus stability counter for one asynchronous input.
module debounce_cell #(
  parameter int   DB_CYC  = 4,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic run,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DB_CYC + 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= {2{RST_VAL}};
      stable <= RST_VAL;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      // During init the stable level tracks the input silently
      if (!run) begin
        stable <= sync[1];
        cnt    <= '0;
      end else if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYC - 1)) begin
        stable <= sync[1];
        cnt    <= '0;
        rise   <= sync[1];
        fall   <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronise/debounce DE0 keys and switches, emit press/release/change pulses.
// Optional KEY_AUTOREPEAT_EN adds periodic key_press pulses while a key stays held.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_KEYS        = 3,
  parameter int N_SW          = 9,
  parameter int CLK_HZ        = 50_000_000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int REPEAT_DLY_MS = 500,
  parameter int REPEAT_PER_MS = 100
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [N_KEYS-1:0] key_n_raw,
  input  logic [N_SW-1:0]   sw_raw,
  output logic [N_KEYS-1:0] key_export,
  output logic [N_SW-1:0]   sw_export,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              sw_change,
  output logic              init_done
);
  localparam int DB_CYC = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int TW     = $clog2(DB_CYC + 1);
  state_t            state;
  logic [TW-1:0]     timer;
  logic [N_KEYS-1:0] k_rise, k_fall;
  logic [N_SW-1:0]   s_rise, s_fall;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= INIT;
      timer     <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      timer <= timer + 1'b1;
      if (timer == TW'(DB_CYC - 1)) begin
        state     <= RUN;
        init_done <= 1'b1;
      end
    end
  end
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    debounce_cell #(.DB_CYC(DB_CYC), .RST_VAL(1'b1)) u_cell (
      .clk(clk_clk), .rst_n(reset_reset_n), .raw(key_n_raw[i]), .run(init_done),
      .stable(key_export[i]), .rise(k_rise[i]), .fall(k_fall[i])
    );
  end
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_cell #(.DB_CYC(DB_CYC), .RST_VAL(1'b0)) u_cell (
      .clk(clk_clk), .rst_n(reset_reset_n), .raw(sw_raw[i]), .run(init_done),
      .stable(sw_export[i]), .rise(s_rise[i]), .fall(s_fall[i])
    );
  end
  assign key_release = k_rise;
  assign sw_change   = |(s_rise | s_fall);
`ifdef KEY_AUTOREPEAT_EN
  localparam int RD = ms_to_cyc(CLK_HZ, REPEAT_DLY_MS);
  localparam int RP = ms_to_cyc(CLK_HZ, REPEAT_PER_MS);
  localparam int RW = $clog2(RD + RP + 1);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_rep
    logic [RW-1:0] rcnt, rnxt;
    logic          rep;
    // Counter wraps back to RD so each period lands on the same pulse value
    assign rnxt = (rcnt == RW'(RD + RP - 1)) ? RW'(RD) : rcnt + 1'b1;
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        rcnt <= '0;
        rep  <= 1'b0;
      end else begin
        rcnt <= key_export[i] ? '0 : rnxt;
        rep  <= ~key_export[i] & (rnxt == RW'(RD));
      end
    end
    assign key_press[i] = k_fall[i] | (rep & ~key_export[i]);
  end
`else
  assign key_press = k_fall;
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus with a history-based reference model and literal checks.
module tb_input_conditioner;
  localparam int RD = 20, RP = 5, DB = 4;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [2:0] key_n_raw = 3'b111;
  logic [8:0] sw_raw = 9'h000;
  logic [2:0] key_export, key_press, key_release;
  logic [8:0] sw_export;
  logic       sw_change, init_done;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .N_KEYS(3), .N_SW(9), .CLK_HZ(1000), .DEBOUNCE_MS(4),
    .REPEAT_DLY_MS(20), .REPEAT_PER_MS(5)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .key_n_raw(key_n_raw), .sw_raw(sw_raw),
    .key_export(key_export), .sw_export(sw_export), .key_press(key_press),
    .key_release(key_release), .sw_change(sw_change), .init_done(init_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an input level is accepted once DB consecutive synchronised samples disagree with it
  logic [11:0] hist[$];
  int          n = 0;
  int          acc[3];
  logic [2:0]  m_key = 3'b111, m_press = 3'b000, m_rel = 3'b000;
  logic [8:0]  m_sw = 9'h000;
  logic        m_chg = 1'b0, m_init = 1'b0;

  always @(posedge clk) begin
    logic [11:0] cur, nx, w;
    bit all;
    if (!rst_n) begin
      n = 0;
      hist.delete();
      hist.push_back(12'h007);
      hist.push_back(12'h007);
      m_key = 3'b111; m_sw = '0; m_press = '0; m_rel = '0; m_chg = 0; m_init = 0;
    end else begin
      n++;
      hist.push_back({sw_raw, key_n_raw});
      cur = {m_sw, m_key};
      nx = cur;
      m_press = '0; m_rel = '0; m_chg = 0;
      if (n <= DB) nx = hist[hist.size() - 3];
      else
        for (int b = 0; b < 12; b++) begin
          all = 1;
          for (int j = 3; j < 3 + DB; j++) begin
            w = hist[hist.size() - j];
            if (w[b] == cur[b]) all = 0;
          end
          if (all) nx[b] = ~cur[b];
        end
      for (int k = 0; k < 3; k++) begin
        if (cur[k] && !nx[k]) acc[k] = n;
        if (n > DB) begin
          if (cur[k] && !nx[k]) m_press[k] = 1;
          if (!cur[k] && nx[k]) m_rel[k] = 1;
`ifdef KEY_AUTOREPEAT_EN
          if (!cur[k] && !nx[k] && n - acc[k] >= RD && (n - acc[k] - RD) % RP == 0) m_press[k] = 1;
`endif
        end
      end
      if (n > DB) m_chg = (nx[11:3] != cur[11:3]);
      m_key = nx[2:0];
      m_sw = nx[11:3];
      m_init = (n >= DB);
      if (hist.size() > 10) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("key_export", key_export, m_key);
    chk("sw_export", sw_export, m_sw);
    chk("key_press", key_press, m_press);
    chk("key_release", key_release, m_rel);
    chk("sw_change", sw_change, m_chg);
    chk("init_done", init_done, m_init);
  end

  int pc[3], rc[3], cc, lat0;
  int p2[$];

  task automatic clr();
    for (int k = 0; k < 3; k++) begin pc[k] = 0; rc[k] = 0; end
    cc = 0; lat0 = 0; p2.delete();
  endtask

  task automatic obs(input int cyc);
    for (int i = 1; i <= cyc; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin pc[k] += int'(key_press[k]); rc[k] += int'(key_release[k]); end
      cc += int'(sw_change);
      if (key_press[2]) p2.push_back(i);
      if (lat0 == 0 && key_export[0] == 1'b0) lat0 = i;
    end
    #1;
  endtask

  initial begin
    int t;
    sw_raw = 9'h155;
    repeat (2) @(negedge clk);
    chk("rst_key", key_export, 3'b111);
    chk("rst_init", init_done, 0);
    #1 rst_n = 1'b1;
    // init phase
    t = 0; clr();
    for (int i = 1; i <= 10 && t == 0; i++) begin
      @(negedge clk);
      cc += int'(sw_change);
      if (init_done) t = i;
    end
    #1;
    chk("init_cycle", t, 4);
    obs(3);
    chk("init_sw", sw_export, 9'h155);
    chk("init_chg", cc, 0);
    // accepted press of key 0
    clr(); key_n_raw[0] = 1'b0; obs(12);
    chk("press_lat", lat0, 6);
    chk("press_cnt", pc[0], 1);
    chk("press_rel", rc[0], 0);
    clr(); key_n_raw[0] = 1'b1; obs(10);
    chk("rel_cnt", rc[0], 1);
    chk("rel_press", pc[0], 0);
    // 3-cycle glitch on key 1
    clr(); key_n_raw[1] = 1'b0; obs(3); key_n_raw[1] = 1'b1; obs(10);
    chk("glitch_key", key_export, 3'b111);
    chk("glitch_evt", pc[1] + rc[1], 0);
    // two switches toggle together
    clr(); sw_raw = sw_raw ^ 9'h084; obs(10);
    chk("sw_chg_cnt", cc, 1);
    chk("sw_val", sw_export, 9'h1D1);
    // reset during a debounce
    key_n_raw[2] = 1'b0; obs(4);
    rst_n = 1'b0; obs(1);
    chk("mid_rst_key", key_export, 3'b111);
    chk("mid_rst_sw", sw_export, 9'h000);
    chk("mid_rst_init", init_done, 0);
    rst_n = 1'b1; clr(); obs(10);
    chk("reinit_done", init_done, 1);
    chk("reinit_key", key_export, 3'b011);
    chk("reinit_sw", sw_export, 9'h1D1);
    chk("reinit_evt", pc[2] + cc, 0);
    key_n_raw[2] = 1'b1; obs(10);
    chk("reinit_rel", rc[2], 1);
    // long hold of key 2
    clr(); key_n_raw[2] = 1'b0; obs(40); key_n_raw[2] = 1'b1; obs(12);
    chk("hold_rel", rc[2], 1);
`ifdef KEY_AUTOREPEAT_EN
    chk("rep_cnt", p2.size(), 5);
    if (p2.size() == 5) begin
      chk("rep_0", p2[0], 6);
      chk("rep_1", p2[1], 26);
      chk("rep_2", p2[2], 31);
      chk("rep_3", p2[3], 36);
      chk("rep_4", p2[4], 41);
    end
`else
    chk("rep_cnt", p2.size(), 1);
    if (p2.size() == 1) chk("rep_0", p2[0], 6);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
